// File: rtl/ram_sp_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-requester command channels
// (valid/ready/wen/lock/addr/din) and the shared read-response group.
interface ram_sp_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_wen;
   logic [NUM_REQ-1:0]            req_lock;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_data;

   // requesters drive commands and receive ready/response
   modport master (
      output req_valid, req_wen, req_lock, req_addr, req_din,
      input  req_ready, rsp_valid, rsp_data
   );

   // the arbiter accepts commands and returns ready/response
   modport slave (
      input  req_valid, req_wen, req_lock, req_addr, req_din,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter in front of a single-port synchronous RAM.
// One beat is granted per cycle; a granted requester may lock the RAM for
// following beats. Reads return a one-cycle rsp_valid pulse to the owner,
// with rsp_data passed straight through from the RAM output.
module ram_sp_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                         clock,
   input  logic                         rst_n,
   ram_sp_arbiter_if.slave              bus,
   output logic                         ram_cen,
   output logic                         ram_wen,
   output logic [$clog2(DEPTH)-1:0]     ram_addr,
   output logic [DATA_WIDTH-1:0]        ram_din,
   input  logic [DATA_WIDTH-1:0]        ram_dout
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_WIDTH-1:0] rr_ptr_q,    rr_ptr_d;
   logic                 lock_vld_q,  lock_vld_d;
   logic [IDX_WIDTH-1:0] lock_idx_q,  lock_idx_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

   logic                 grant_vld_s;
   logic [IDX_WIDTH-1:0] grant_idx_s;

   // (base + step) mod NUM_REQ; with NUM_REQ=1 this is always 0
   function automatic logic [IDX_WIDTH-1:0] idx_add(
      input logic [IDX_WIDTH-1:0] base,
      input logic [31:0]          step
   );
      logic [31:0] sum_v;
      sum_v = 32'(base) + step;
      sum_v = sum_v % 32'(NUM_REQ);
      return sum_v[IDX_WIDTH-1:0];
   endfunction

   // Grant selection: a still-valid lock owner wins, else first valid from rr_ptr
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = {IDX_WIDTH{1'b0}};
      if (lock_vld_q && bus.req_valid[lock_idx_q]) begin
         grant_vld_s = 1'b1;
         grant_idx_s = lock_idx_q;
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            // scanning backwards so the closest-to-rr_ptr candidate is written last
            if (bus.req_valid[idx_add(rr_ptr_q, 32'(k))]) begin
               grant_vld_s = 1'b1;
               grant_idx_s = idx_add(rr_ptr_q, 32'(k));
            end else begin
               grant_vld_s = grant_vld_s;
            end
         end
      end
   end

   // Next state: pointer advance, lock capture/release, read response pulse
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      lock_vld_d  = 1'b0;
      lock_idx_d  = lock_idx_q;
      rsp_valid_d = {NUM_REQ{1'b0}};
      if (grant_vld_s) begin
         rr_ptr_d   = idx_add(grant_idx_s, 32'd1);
         lock_vld_d = bus.req_lock[grant_idx_s];
         lock_idx_d = grant_idx_s;
         if (!bus.req_wen[grant_idx_s]) begin
            rsp_valid_d[grant_idx_s] = 1'b1;
         end else begin
            rsp_valid_d = {NUM_REQ{1'b0}};
         end
      end else begin
         // no grant means the lock owner (if any) has withdrawn its request
         lock_vld_d = 1'b0;
      end
   end

   // State registers; a read in flight at reset loses its response pulse
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= {IDX_WIDTH{1'b0}};
         lock_vld_q  <= 1'b0;
         lock_idx_q  <= {IDX_WIDTH{1'b0}};
         rsp_valid_q <= {NUM_REQ{1'b0}};
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         lock_vld_q  <= lock_vld_d;
         lock_idx_q  <= lock_idx_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // RAM drive and ready: address/data always come from the selected slice
   always_comb begin
      ram_cen  = grant_vld_s;
      ram_wen  = grant_vld_s & bus.req_wen[grant_idx_s];
      ram_addr = bus.req_addr[32'(grant_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
      ram_din  = bus.req_din[32'(grant_idx_s) * DATA_WIDTH +: DATA_WIDTH];
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = grant_vld_s && (grant_idx_s == IDX_WIDTH'(i));
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter with three requesters: directed scenarios plus
// randomized traffic, checked against a plain behavioural model of the
// arbitration rules and of RAM contents kept in the bench.
module tb_ram_sp_arbiter;
   localparam int N     = 3;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          clock;
   logic          rst_n;
   logic          ram_cen;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   ram_sp_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_sp_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock    (clock),
      .rst_n    (rst_n),
      .bus      (bus),
      .ram_cen  (ram_cen),
      .ram_wen  (ram_wen),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   // clock generator
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // single-port RAM fixture: 1-cycle read latency, output held while idle
   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clock) begin
      if (ram_cen) begin
         if (ram_wen) ram_mem[ram_addr] <= ram_din;
         else         ram_dout <= ram_mem[ram_addr];
      end
   end

   // reference model state
   int            m_ptr;
   int            m_lock;
   logic [DW-1:0] m_mem [DEPTH];
   logic [N-1:0]  m_rsp_vld;
   logic [DW-1:0] m_rsp_data;
   int            last_g;
   logic [N-1:0]  obs_ready;
   logic          obs_cen;

   int n_assert;
   int n_fail;

   logic [N-1:0]  rr_seq  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [DW-1:0] rr_data [4] = '{32'h11, 32'h22, 32'h33, 32'h11};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_valid[i]           = v;
      bus.req_wen[i]             = w;
      bus.req_lock[i]            = l;
      bus.req_addr[i*AW +: AW]   = a;
      bus.req_din[i*DW +: DW]    = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
   endtask

   // one clock cycle: predict and check mid-cycle, then advance the model at the edge
   task automatic cycle_check();
      int g;
      int a;
      g = -1;
      @(negedge clock);
      if (m_lock >= 0 && bus.req_valid[m_lock]) begin
         g = m_lock;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      obs_ready = bus.req_ready;
      obs_cen   = ram_cen;
      check("req_ready", 64'(bus.req_ready), (g >= 0) ? 64'(1) << g : 64'd0);
      check("ram_cen", 64'(ram_cen), (g >= 0) ? 64'd1 : 64'd0);
      if (g >= 0) begin
         check("ram_wen",  64'(ram_wen),  64'(bus.req_wen[g]));
         check("ram_addr", 64'(ram_addr), 64'(bus.req_addr[g*AW +: AW]));
         check("ram_din",  64'(ram_din),  64'(bus.req_din[g*DW +: DW]));
      end
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_vld));
      if (m_rsp_vld != 3'b000) check("rsp_data", 64'(bus.rsp_data), 64'(m_rsp_data));
      @(posedge clock);
      if (g >= 0) begin
         a      = int'(bus.req_addr[g*AW +: AW]);
         m_ptr  = (g + 1) % N;
         m_lock = bus.req_lock[g] ? g : -1;
         if (bus.req_wen[g]) begin
            m_mem[a]  = bus.req_din[g*DW +: DW];
            m_rsp_vld = 3'b000;
         end else begin
            m_rsp_vld  = 3'b001 << g;
            m_rsp_data = m_mem[a];
         end
      end else begin
         m_lock    = -1;
         m_rsp_vld = 3'b000;
      end
      last_g = g;
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_assert = 0;
      n_fail   = 0;
      m_ptr    = 0;
      m_lock   = -1;
      m_rsp_vld  = 3'b000;
      m_rsp_data = 32'd0;
      last_g   = -1;
      ram_dout = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = 32'd0;
         m_mem[i]   = 32'd0;
      end
      rst_n = 1'b0;
      clear_all();
      repeat (2) @(posedge clock);
      #1;
      check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("reset_ram_cen",   64'(ram_cen),       64'd0);
      rst_n = 1'b1;

      // write then read of the same word on consecutive cycles
      set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
      cycle_check();
      clear_all();
      set_req(1, 1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
      cycle_check();
      clear_all();
      check("wr_rd_rsp_valid", 64'(bus.rsp_valid), 64'(3'b010));
      check("wr_rd_rsp_data",  64'(bus.rsp_data),  64'(32'hDEADBEEF));

      // preload words 1..3 through requester 2, leaving the pointer at 0
      set_req(2, 1'b1, 1'b1, 1'b0, 4'd1, 32'h11); cycle_check();
      set_req(2, 1'b1, 1'b1, 1'b0, 4'd2, 32'h22); cycle_check();
      set_req(2, 1'b1, 1'b1, 1'b0, 4'd3, 32'h33); cycle_check();
      clear_all();

      // round robin over three continuously valid readers
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0);
      set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 32'd0);
      set_req(2, 1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
      for (int k = 0; k < 4; k++) begin
         cycle_check();
         check("rr_grant",     64'(obs_ready),     64'(rr_seq[k]));
         check("rr_rsp_valid", 64'(bus.rsp_valid), 64'(rr_seq[k]));
         check("rr_rsp_data",  64'(bus.rsp_data),  64'(rr_data[k]));
      end
      clear_all();

      // lock: r1 holds the RAM for four writes while r0 waits
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0);
      for (int b = 0; b < 5; b++) begin
         set_req(1, 1'b1, 1'b1, (b < 3), 4'(4 + b), 32'(32'hA0 + b));
         cycle_check();
         check("lock_grant", 64'(obs_ready), (b < 4) ? 64'(3'b010) : 64'(3'b001));
      end
      set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      cycle_check();
      clear_all();

      // lock owner withdraws; the other requester is served in the same cycle
      set_req(0, 1'b1, 1'b1, 1'b1, 4'd9, 32'h55);
      cycle_check();
      check("lockdrop_first", 64'(obs_ready), 64'(3'b001));
      clear_all();
      set_req(1, 1'b1, 1'b0, 1'b0, 4'd9, 32'd0);
      cycle_check();
      check("lockdrop_grant", 64'(obs_ready), 64'(3'b010));
      check("lockdrop_cen",   64'(obs_cen),   64'd1);
      check("lockdrop_data",  64'(bus.rsp_data), 64'(32'h55));
      clear_all();

      // idle cycles keep the pointer (at 2) and drive nothing
      for (int k = 0; k < 10; k++) begin
         cycle_check();
         check("idle_cen",       64'(obs_cen),       64'd0);
         check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      end
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 4'(i), 32'd0);
      cycle_check();
      check("idle_ptr_kept", 64'(obs_ready), 64'(3'b100));
      clear_all();
      cycle_check();

      // reset right after a read is accepted: response dropped, pointer back to 0
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
      cycle_check();
      clear_all();
      rst_n = 1'b0;
      #2;
      check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_mid_cen",       64'(ram_cen),       64'd0);
      m_ptr     = 0;
      m_lock    = -1;
      m_rsp_vld = 3'b000;
      @(posedge clock);
      #1;
      check("rst_hold_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      rst_n = 1'b1;
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
      set_req(1, 1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
      cycle_check();
      check("rst_first_grant", 64'(obs_ready), 64'(3'b001));
      clear_all();
      cycle_check();

      // randomized traffic: pending requests held until accepted
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(bus.req_valid[i] && last_g != i)) begin
               set_req(i, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                       ($urandom_range(0, 3) == 0), 4'($urandom_range(0, DEPTH - 1)),
                       32'($urandom));
            end
         end
         cycle_check();
      end
      clear_all();
      repeat (3) cycle_check();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
